// File: rtl/piso_reg.sv
// Parallel-in serial-out transmit register: accepts a word over valid/ready and
// shifts it out one bit per shift_en, with a per-bit valid strobe and a done pulse.
module piso_reg #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx, sreg_shifted;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             done_nx;
    logic             last_bit;
    logic             accept;

    // Last bit of the word in flight is being consumed this cycle.
    assign last_bit = (state == SHIFT) && (cnt == '0) && shift_en;
    assign in_ready = rst && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid && (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]);

    // Move the next bit toward the output end, zero-filling behind it.
    always_comb begin
        if (LSB_FIRST) begin
            sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end else begin
            sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        if (state == IDLE) begin
            if (accept) begin
                sreg_nx  = in;
                cnt_nx   = CW'(WIDTH - 1);
                state_nx = SHIFT;
            end
        end else if (shift_en) begin
            if (cnt != '0) begin
                sreg_nx = sreg_shifted;
                cnt_nx  = cnt - CW'(1);
            end else begin
                done_nx = 1'b1;
                // Back-to-back reload keeps the link busy without an idle cycle.
                if (accept) begin
                    sreg_nx = in;
                    cnt_nx  = CW'(WIDTH - 1);
                end else begin
                    sreg_nx  = '0;
                    state_nx = IDLE;
                end
            end
        end
    end

endmodule
